mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares one multi-cycle main-memory port between the instruction-fetch path (single-word reads) and the data cache (single-word or line-burst reads/writes for refill/writeback). Round-robin on contention, burst address sequencing, per-beat wait timeout. Sits between instr_mem/cache and the backing memory model below top.

Parameters:
BURST_LEN, 4, words per data-port burst (power of two, >=2)
TIMEOUT, 255, max cycles waiting for mem_ready on one beat before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
i_req  in  1  instruction read request, level, held until i_done
i_addr  in  32  instruction byte address, stable while i_req
i_rdata  out  32  = mem_rdata passthrough
i_rvalid  out  1  i_rdata valid this cycle
i_done  out  1  transaction finished this cycle
i_err  out  1  timeout abort, coincident with i_done
d_req  in  1  data request, level, held until d_done
d_we  in  1  1=write, 0=read, stable while d_req
d_burst  in  1  1=BURST_LEN beats, 0=single word
d_addr  in  32  byte address, stable while d_req
d_wdata  in  32  write data for current d_beat (combinational from requester)
d_rdata  out  32  = mem_rdata passthrough
d_rvalid  out  1  beat accepted/returned this cycle
d_beat  out  $clog2(BURST_LEN)  current beat index
d_done  out  1  transaction finished this cycle
d_err  out  1  timeout abort, coincident with d_done
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write strobe
mem_addr  out  32  word address for current beat
mem_wdata  out  32  = d_wdata while data port owns, else 0
mem_rdata  in  32  read data, valid with mem_ready
mem_ready  in  1  beat complete
busy  out  1  state==BUSY
owner  out  1  0=instruction, 1=data; value of last grant
stat_i_grants, stat_d_grants, stat_stall  out  32 each  statistics (see Optional Feature)

Behaviour:
- FSM: IDLE, BUSY. Reset -> IDLE, beat=0, wait_cnt=0, last_grant=1 (instruction wins first tie), owner=0. All 1-bit outputs 0 in IDLE; rdata outputs passthrough.
- IDLE: sample reqs. One req -> grant it. Both -> grant !last_grant. On grant: latch owner, we (I: 0), burst (I: 0), base addr; last_grant<=owner; -> BUSY next edge. Grant latency: 1 cycle from req to mem_req.
- Base: burst -> {addr[31:$clog2(BURST_LEN)+2], 0}; single -> {addr[31:2],2'b00}. mem_addr = base + {beat,2'b00}; no carry beyond line.
- BUSY: mem_req=1. Owner's rvalid = mem_ready (comb). On mem_ready: wait_cnt<=0; if last beat (beat==BURST_LEN-1, or single) -> done=1 same cycle, beat<=0, -> IDLE; else beat++.
- No mem_ready: wait_cnt++; at wait_cnt==TIMEOUT-1 with no ready -> done=1, err=1, -> IDLE, beat<=0. Ready on that cycle wins (no err).
- Requester must drop req on edge where done=1; arbiter returns to IDLE the same edge, so back-to-back requests need a 1-cycle idle gap per port; other port may be granted immediately.
- Non-owner outputs (rvalid/done/err) stay 0. Reqs changing while BUSY are ignored.
- Reset mid-burst: immediate async clear; mem_req drops without waiting for mem_ready.

Optional Feature:
ARB_STATS_EN: defined -> stat_i_grants/stat_d_grants increment on each grant; stat_stall increments each cycle where any req is high and its port is not owning BUSY (both waiting counts +1); all saturate at 0xFFFFFFFF, reset 0. Undefined -> stat ports tied 0, no counter flops.

Decomposition:
- Package mem_arb_pkg: state enum (ST_IDLE, ST_BUSY), owner enum (OWN_I=0, OWN_D=1), word-offset constant 2.
- Sub-module mem_arb_stats (three saturating counters), instantiated only under ARB_STATS_EN.

Test Plan:
- rst=0 for 2 cycles mid-burst (beat 2) -> mem_req=0, busy=0 same cycle; after release, simultaneous i_req/d_req -> owner=0 granted first.
- i_req, i_addr=0xBFC00004, mem_ready after 2 wait cycles with mem_rdata=0x00500093 -> mem_addr=0xBFC00004, i_rvalid=i_done=1 same cycle, i_rdata=0x00500093, busy=0 next cycle.
- Continuous both reqs (each dropping/reasserting per rule) -> grants alternate I,D,I,D; owner toggles each transaction.
- d_req burst read d_addr=0x00010014, BURST_LEN=4, mem_ready every cycle -> mem_addr 0x10010,0x10014,0x10018,0x1001C, d_beat 0..3, d_done on 4th beat.
- Burst write, d_wdata=0xA0+beat -> mem_we=1, mem_wdata 0xA0,0xA1,0xA2,0xA3 aligned with beats.
- TIMEOUT=8, mem_ready held 0 -> d_done=d_err=1 on 8th BUSY cycle, mem_req=0 next; with ARB_STATS_EN, stat_d_grants=1 and stat_stall counts waiting-I cycles exactly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter.
// No logic: compile-time definitions only.
// No flow control: consumed by mem_arbiter and mem_arb_stats.
package mem_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Byte-to-word address shift.
    localparam int WORD_OFF = 2;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating grant and stall counters for the memory arbiter.
// Latency: counters update on the edge after the qualifying cycle.
// No backpressure: pure observers, each counter sticks at all-ones.
module mem_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_grant,
    input  logic        d_grant,
    input  logic        i_wait,
    input  logic        d_wait,
    output logic [31:0] stat_i_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_stall
);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [1:0] stall_inc;
    assign stall_inc = {1'b0, i_wait} + {1'b0, d_wait};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_i_grants <= '0;
            stat_d_grants <= '0;
            stat_stall    <= '0;
        end else begin
            stat_i_grants <= sat_add(stat_i_grants, {1'b0, i_grant});
            stat_d_grants <= sat_add(stat_d_grants, {1'b0, d_grant});
            stat_stall    <= sat_add(stat_stall, stall_inc);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin share of one memory port between instruction fetch and data cache; ARB_STATS_EN adds counters.
// Latency: mem_req one cycle after the winning req; done/err combinational with the final mem_ready or timeout.
// Backpressure: each beat waits on mem_ready up to TIMEOUT cycles, then aborts with err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [31:0]                  i_addr,
    output logic [31:0]                  i_rdata,
    output logic                         i_rvalid,
    output logic                         i_done,
    output logic                         i_err,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic                         d_burst,
    input  logic [31:0]                  d_addr,
    input  logic [31:0]                  d_wdata,
    output logic [31:0]                  d_rdata,
    output logic                         d_rvalid,
    output logic [$clog2(BURST_LEN)-1:0] d_beat,
    output logic                         d_done,
    output logic                         d_err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata,
    input  logic                         mem_ready,
    output logic                         busy,
    output logic                         owner,
    output logic [31:0]                  stat_i_grants,
    output logic [31:0]                  stat_d_grants,
    output logic [31:0]                  stat_stall
);

    localparam int BW = $clog2(BURST_LEN);

    logic [0:0]    state;
    owner_e        own_q;
    owner_e        last_grant;
    logic          we_q;
    logic          burst_q;
    logic [31:0]   base_q;
    logic [BW-1:0] beat;
    logic [7:0]    wait_cnt;

    logic          grant_any;
    owner_e        grant_sel;
    logic [31:0]   sel_addr;
    logic          sel_burst;
    logic [31:0]   sel_mask;
    logic          last_beat;
    logic          expire;
    logic          fin;

    assign busy      = (state == ST_BUSY);
    assign grant_any = !busy && (i_req || d_req);
    // On a tie the port that did not win last time goes next.
    assign grant_sel = (d_req && (!i_req || last_grant == OWN_I)) ? OWN_D : OWN_I;
    assign sel_addr  = (grant_sel == OWN_D) ? d_addr : i_addr;
    assign sel_burst = (grant_sel == OWN_D) && d_burst;
    assign sel_mask  = sel_burst ? 32'((BURST_LEN << WORD_OFF) - 1) : 32'((1 << WORD_OFF) - 1);

    assign last_beat = !burst_q || (beat == BW'(BURST_LEN - 1));
    assign expire    = !mem_ready && (wait_cnt == 8'(TIMEOUT - 1));
    assign fin       = busy && ((mem_ready && last_beat) || expire);

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    // Base is line/word aligned, so OR-ing the beat offset never carries out of the line.
    assign mem_addr  = base_q | {{(32 - BW - WORD_OFF){1'b0}}, beat, {WORD_OFF{1'b0}}};
    assign mem_wdata = (busy && own_q == OWN_D) ? d_wdata : 32'h0;

    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_rvalid  = busy && (own_q == OWN_I) && mem_ready;
    assign d_rvalid  = busy && (own_q == OWN_D) && mem_ready;
    assign i_done    = fin && (own_q == OWN_I);
    assign d_done    = fin && (own_q == OWN_D);
    assign i_err     = busy && expire && (own_q == OWN_I);
    assign d_err     = busy && expire && (own_q == OWN_D);
    assign d_beat    = beat;
    assign owner     = own_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            own_q      <= OWN_I;
            last_grant <= OWN_D;
            we_q       <= 1'b0;
            burst_q    <= 1'b0;
            base_q     <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
        end else if (!busy) begin
            if (grant_any) begin
                state      <= ST_BUSY;
                own_q      <= grant_sel;
                last_grant <= grant_sel;
                we_q       <= (grant_sel == OWN_D) && d_we;
                burst_q    <= sel_burst;
                base_q     <= sel_addr & ~sel_mask;
                beat       <= '0;
                wait_cnt   <= '0;
            end
        end else if (mem_ready) begin
            wait_cnt <= '0;
            if (last_beat) begin
                beat  <= '0;
                state <= ST_IDLE;
            end else begin
                beat <= beat + 1'b1;
            end
        end else if (expire) begin
            wait_cnt <= '0;
            beat     <= '0;
            state    <= ST_IDLE;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

`ifdef ARB_STATS_EN
    mem_arb_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .i_grant       (grant_any && grant_sel == OWN_I),
        .d_grant       (grant_any && grant_sel == OWN_D),
        .i_wait        (i_req && !(busy && own_q == OWN_I)),
        .d_wait        (d_req && !(busy && own_q == OWN_D)),
        .stat_i_grants (stat_i_grants),
        .stat_d_grants (stat_d_grants),
        .stat_stall    (stat_stall)
    );
`else
    assign stat_i_grants = '0;
    assign stat_d_grants = '0;
    assign stat_stall    = '0;
`endif

endmodule
